// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array control sequencer.
package tpu_pkg;

    // Sequencer phases.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_COMPUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Command opcodes.
    localparam logic [3:0] OP_RUN  = 4'h1;
    localparam logic [3:0] OP_LOAD = 4'h2;
    localparam logic [3:0] OP_CWB  = 4'h3;

    // Address width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tpu_beat_counter.sv
// Beat counter with synchronous clear, enable, wrap at LAST and a last-beat flag.
module tpu_beat_counter #(
    parameter int W    = 1,
    parameter int LAST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign last  = (count_q == W'(LAST));
    assign count = count_q;

    // Clear has priority; an enabled beat on the last value wraps to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Control sequencer for a DIM x DIM systolic matrix unit: operand load,
// fixed-length compute window and result writeback, with abort and status.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int  DIM            = 2,
    parameter int  COMPUTE_CYCLES = 3*DIM-1,
    localparam int AW             = $clog2(2*DIM*DIM),
    localparam int RW             = clog2_min1(DIM*DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    instr,
    input  logic          abort,
    input  logic          host_valid,
    input  logic          host_wb_ready,
    output logic          host_req_mat,
    output logic          wm_load_mat,
    output logic [AW-1:0] wm_addr,
    output logic          load_mmu,
    output logic          host_mat_wb,
    output logic [RW-1:0] wb_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q, state_d;
    logic          wts_valid_q, wts_valid_d;
    logic          load_only_q, load_only_d;
    logic          host_req_mat_q, host_req_mat_d;
    logic          load_mmu_q, load_mmu_d;
    logic          host_mat_wb_q, host_mat_wb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [AW-1:0] load_cnt;
    logic          load_last;
    logic [RW-1:0] wb_cnt;
    logic          wb_last;
    logic          compute_last;
    logic          phase_change;
    logic          load_en;
    logic          wb_en;

    // The load counter doubles as the compute-window timer; any phase
    // change (including abort) clears both counters.
    assign phase_change = (state_d != state_q);
    assign load_en      = ((state_q == S_LOAD) && host_valid) || (state_q == S_COMPUTE);
    assign wb_en        = (state_q == S_WRITEBACK) && host_wb_ready;
    assign compute_last = (load_cnt == AW'(COMPUTE_CYCLES-1));

    tpu_beat_counter #(
        .W    (AW),
        .LAST (2*DIM*DIM-1)
    ) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_change),
        .en    (load_en),
        .count (load_cnt),
        .last  (load_last)
    );

    tpu_beat_counter #(
        .W    (RW),
        .LAST (DIM*DIM-1)
    ) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_change),
        .en    (wb_en),
        .count (wb_cnt),
        .last  (wb_last)
    );

    // Next-state and registered-output decode; abort overrides every busy phase.
    always_comb begin
        state_d     = state_q;
        wts_valid_d = wts_valid_q;
        load_only_d = load_only_q;
        err_d       = 1'b0;
        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
            if (state_q == S_LOAD) begin
                wts_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        load_only_d = (instr == OP_LOAD);
                        if ((instr == OP_RUN) || (instr == OP_LOAD)) begin
                            state_d = S_LOAD;
                        end else if ((instr == OP_CWB) && wts_valid_q) begin
                            state_d = S_COMPUTE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (host_valid && load_last) begin
                        wts_valid_d = 1'b1;
                        state_d     = load_only_q ? S_DONE : S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (compute_last) begin
                        state_d = S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (host_wb_ready && wb_last) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        host_req_mat_d = (state_d == S_LOAD);
        load_mmu_d     = (state_d == S_COMPUTE);
        host_mat_wb_d  = (state_d == S_WRITEBACK);
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
    end

    // State, operand-valid flag and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wts_valid_q    <= 1'b0;
            load_only_q    <= 1'b0;
            host_req_mat_q <= 1'b0;
            load_mmu_q     <= 1'b0;
            host_mat_wb_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wts_valid_q    <= wts_valid_d;
            load_only_q    <= load_only_d;
            host_req_mat_q <= host_req_mat_d;
            load_mmu_q     <= load_mmu_d;
            host_mat_wb_q  <= host_mat_wb_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign host_req_mat = host_req_mat_q;
    assign wm_load_mat  = host_req_mat_q & host_valid;
    assign wm_addr      = load_cnt;
    assign load_mmu     = load_mmu_q;
    assign host_mat_wb  = host_mat_wb_q;
    assign wb_addr      = wb_cnt;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Randomised bench for tpu_sequencer: two instances (DIM=2 and DIM=4) share
// the stimulus, start is steered to one of them, and observed transactions
// are compared against a phase-level model of each command.
`timescale 1ns/1ps
module tb_tpu_sequencer;

    localparam int BUDGET = 400;

    typedef struct packed {
        logic [3:0] op;
        int         vm;    // host_valid percentage, -1 = alternate 1,0,1,0
        int         rm;    // host_wb_ready percentage, -1 = low for first 3 wb cycles
        int         ab;    // abort on this load beat, -1 = none
        int         am;    // abort on this compute cycle, -1 = none
        bit         aos;   // abort together with start
        bit         noise; // spurious start pulses while busy
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel4;
    logic       start, abort, host_valid, host_wb_ready;
    logic [3:0] instr;
    logic       start_2, start_4;

    logic       host_req_mat_2, wm_load_mat_2, load_mmu_2, host_mat_wb_2, busy_2, done_2, err_2;
    logic [2:0] wm_addr_2;
    logic [1:0] wb_addr_2;
    logic       host_req_mat_4, wm_load_mat_4, load_mmu_4, host_mat_wb_4, busy_4, done_4, err_4;
    logic [4:0] wm_addr_4;
    logic [3:0] wb_addr_4;

    assign start_2 = start & ~sel4;
    assign start_4 = start & sel4;

    tpu_sequencer #(.DIM(2)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_2),
        .instr         (instr),
        .abort         (abort),
        .host_valid    (host_valid),
        .host_wb_ready (host_wb_ready),
        .host_req_mat  (host_req_mat_2),
        .wm_load_mat   (wm_load_mat_2),
        .wm_addr       (wm_addr_2),
        .load_mmu      (load_mmu_2),
        .host_mat_wb   (host_mat_wb_2),
        .wb_addr       (wb_addr_2),
        .busy          (busy_2),
        .done          (done_2),
        .err           (err_2)
    );

    tpu_sequencer #(.DIM(4)) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_4),
        .instr         (instr),
        .abort         (abort),
        .host_valid    (host_valid),
        .host_wb_ready (host_wb_ready),
        .host_req_mat  (host_req_mat_4),
        .wm_load_mat   (wm_load_mat_4),
        .wm_addr       (wm_addr_4),
        .load_mmu      (load_mmu_4),
        .host_mat_wb   (host_mat_wb_4),
        .wb_addr       (wb_addr_4),
        .busy          (busy_4),
        .done          (done_4),
        .err           (err_4)
    );

    // Outputs of whichever instance is currently under test.
    logic o_req, o_wm_load, o_mmu, o_wb, o_busy, o_done, o_err;
    int   o_wm_addr, o_wb_addr;
    always_comb begin
        if (sel4) begin
            o_req = host_req_mat_4; o_wm_load = wm_load_mat_4; o_mmu = load_mmu_4;
            o_wb = host_mat_wb_4; o_busy = busy_4; o_done = done_4; o_err = err_4;
            o_wm_addr = int'(wm_addr_4); o_wb_addr = int'(wb_addr_4);
        end else begin
            o_req = host_req_mat_2; o_wm_load = wm_load_mat_2; o_mmu = load_mmu_2;
            o_wb = host_mat_wb_2; o_busy = busy_2; o_done = done_2; o_err = err_2;
            o_wm_addr = int'(wm_addr_2); o_wb_addr = int'(wb_addr_2);
        end
    end

    int    checks = 0;
    int    errors = 0;
    int    obs_wm[$];
    int    obs_wb[$];
    int    obs_mmu, obs_runs, obs_done, obs_err, obs_busy, obs_req;
    string obs_fin;
    bit    obs_to;
    bit    model_wts [2];

    function automatic cmd_t mk(input logic [3:0] op, input int vm, input int rm, input int ab,
                                input int am, input bit aos, input bit noise);
        cmd_t c;
        c.op = op; c.vm = vm; c.rm = rm; c.ab = ab; c.am = am; c.aos = aos; c.noise = noise;
        return c;
    endfunction

    function automatic string q_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d,", q[i])};
        return s;
    endfunction

    function automatic string seq_str(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, $sformatf("%0d,", i)};
        return s;
    endfunction

    function automatic string fmt(input string wm, input string wb, input int mmu, input int runs,
                                  input int dn, input int er, input string fin, input bit to);
        return $sformatf("wm=[%s] wb=[%s] mmu=%0d runs=%0d done=%0d err=%0d fin=%s to=%0d",
                         wm, wb, mmu, runs, dn, er, fin, to);
    endfunction

    function automatic string observed();
        return fmt(q_str(obs_wm), q_str(obs_wb), obs_mmu, obs_runs, obs_done, obs_err, obs_fin, obs_to);
    endfunction

    // Command-level model: which phases a command runs, how many beats each
    // phase transfers, and how the stored-operand flag evolves.
    function automatic string predict(input cmd_t c);
        int d, nl, nc, nw;
        bit legal, ab_load, ab_mmu;
        d = sel4 ? 4 : 2;
        nl = 0; nc = 0; nw = 0; ab_load = 0; ab_mmu = 0;
        legal = (c.op == 4'h1) || (c.op == 4'h2) || ((c.op == 4'h3) && model_wts[sel4]);
        if (legal) begin
            if (c.op != 4'h3) nl = 2*d*d;
            if (c.op != 4'h2) begin nc = 3*d-1; nw = d*d; end
            ab_load = (c.ab >= 0) && (nl > 0);
            ab_mmu  = !ab_load && (c.am >= 0) && (nc > 0);
            if (ab_load) begin
                nl = c.ab + 1; nc = 0; nw = 0; model_wts[sel4] = 1'b0;
            end else begin
                if (nl > 0) model_wts[sel4] = 1'b1;
                if (ab_mmu) begin nc = c.am + 1; nw = 0; end
            end
        end
        return fmt(seq_str(nl), seq_str(nw), nc, (nc > 0) ? 1 : 0,
                   (legal && !ab_load && !ab_mmu) ? 1 : 0, legal ? 0 : 1, "0000000/0/0", 1'b0);
    endfunction

    // Issue one command and record every transaction until the sequencer is idle again.
    task automatic run_cmd(input cmd_t c);
        int wb_cycles = 0;
        bit prev_mmu  = 1'b0;
        bit fin_seen  = 1'b0;
        obs_wm.delete(); obs_wb.delete();
        obs_mmu = 0; obs_runs = 0; obs_done = 0; obs_err = 0; obs_busy = 0; obs_req = 0;
        obs_fin = "none";
        @(negedge clk);
        start = 1'b1; instr = c.op; abort = c.aos; host_valid = 1'b0; host_wb_ready = 1'b0;
        for (int k = 1; k <= BUDGET && !fin_seen; k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (c.noise && o_busy) begin
                start = 1'($urandom_range(0, 1));
                instr = 4'($urandom_range(0, 15));
            end
            if (c.vm < 0) host_valid = (k % 2 == 1);
            else          host_valid = (int'($urandom_range(0, 99)) < c.vm);
            if (c.rm < 0) host_wb_ready = (wb_cycles >= 3);
            else          host_wb_ready = (int'($urandom_range(0, 99)) < c.rm);
            if (c.ab >= 0 && o_req && obs_wm.size() == c.ab) begin
                abort = 1'b1; host_valid = 1'b1;
            end
            if (c.am >= 0 && o_mmu && obs_mmu == c.am) abort = 1'b1;
            #1;
            if (o_wm_load) obs_wm.push_back(o_wm_addr);
            if (o_wb && host_wb_ready) obs_wb.push_back(o_wb_addr);
            if (o_mmu) begin
                obs_mmu++;
                if (!prev_mmu) obs_runs++;
            end
            prev_mmu = o_mmu;
            obs_done += int'(o_done); obs_err += int'(o_err);
            obs_busy += int'(o_busy); obs_req += int'(o_req);
            if (o_wb) wb_cycles++;
            if (k >= 2 && !o_busy && !o_err) begin
                fin_seen = 1'b1;
                obs_fin = $sformatf("%b%b%b%b%b%b%b/%0d/%0d", o_req, o_wm_load, o_mmu, o_wb,
                                    o_busy, o_done, o_err, o_wm_addr, o_wb_addr);
            end
        end
        obs_to = !fin_seen;
        start = 1'b0; abort = 1'b0; host_valid = 1'b0; host_wb_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; host_valid = 1'b0; host_wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_wts[0] = 1'b0; model_wts[1] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel4 = 1'b0; start = 1'b1; instr = 4'h1; abort = 1'b0;
        host_valid = 1'b1; host_wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({host_req_mat_2, wm_load_mat_2, load_mmu_2, host_mat_wb_2, busy_2, done_2, err_2,
             wm_addr_2, wb_addr_2} !== 12'd0) begin
            errors++;
            $display("FAIL reset_dim2 got req=%b wml=%b mmu=%b wb=%b busy=%b done=%b err=%b wa=%0d ra=%0d exp all 0",
                     host_req_mat_2, wm_load_mat_2, load_mmu_2, host_mat_wb_2, busy_2, done_2, err_2,
                     wm_addr_2, wb_addr_2);
        end
        checks++;
        if ({host_req_mat_4, wm_load_mat_4, load_mmu_4, host_mat_wb_4, busy_4, done_4, err_4,
             wm_addr_4, wb_addr_4} !== 16'd0) begin
            errors++;
            $display("FAIL reset_dim4 got req=%b wml=%b mmu=%b wb=%b busy=%b done=%b err=%b wa=%0d ra=%0d exp all 0",
                     host_req_mat_4, wm_load_mat_4, load_mmu_4, host_mat_wb_4, busy_4, done_4, err_4,
                     wm_addr_4, wb_addr_4);
        end
        start = 1'b0; host_valid = 1'b0; host_wb_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_wts[0] = 1'b0; model_wts[1] = 1'b0;
    endtask

    task automatic test_run();
        cmd_t  c;
        string exp_s, got_s;
        sel4 = 1'b0;
        c = mk(4'h1, 100, 100, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL run_full got %s exp %s", got_s, exp_s); end
        checks++;
        if (obs_busy != 8 + 5 + 4 + 1) begin
            errors++; $display("FAIL run_busy_cycles got %0d exp %0d", obs_busy, 18);
        end
        checks++;
        if (obs_req != 8) begin
            errors++; $display("FAIL run_req_cycles got %0d exp %0d", obs_req, 8);
        end
    endtask

    task automatic test_backpressure();
        cmd_t  c;
        string exp_s, got_s;
        sel4 = 1'b0;
        c = mk(4'h1, -1, -1, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL bp_toggle got %s exp %s", got_s, exp_s); end
        checks++;
        if (obs_req != 15) begin errors++; $display("FAIL bp_req_cycles got %0d exp %0d", obs_req, 15); end
        checks++;
        if (obs_busy != 15 + 5 + 7 + 1) begin
            errors++; $display("FAIL bp_busy_cycles got %0d exp %0d", obs_busy, 28);
        end
        c = mk(4'h1, 50, 30, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL bp_random got %s exp %s", got_s, exp_s); end
    endtask

    task automatic test_modes();
        cmd_t       tbl[$];
        string      exp_s, got_s;
        logic [3:0] bad;
        do_reset();
        sel4 = 1'b0;
        bad = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(4, 15));
        tbl.push_back(mk(4'h3, 100, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h2, 80, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h3, 100, 70, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'hF, 100, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(bad, 100, 100, -1, -1, 1'b0, 1'b0));
        foreach (tbl[i]) begin
            exp_s = predict(tbl[i]);
            run_cmd(tbl[i]);
            got_s = observed();
            checks++;
            if (got_s != exp_s) begin
                errors++; $display("FAIL mode[%0d] op=%h got %s exp %s", i, tbl[i].op, got_s, exp_s);
            end
        end
    endtask

    task automatic test_abort();
        cmd_t  tbl[$];
        string exp_s, got_s;
        do_reset();
        sel4 = 1'b0;
        tbl.push_back(mk(4'h1, 70, 100, 5, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h3, 100, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h2, 100, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h1, 100, 100, 7, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h3, 100, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h2, 60, 100, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h1, 100, 100, -1, 2, 1'b0, 1'b0));
        tbl.push_back(mk(4'h3, 100, 50, -1, -1, 1'b0, 1'b0));
        tbl.push_back(mk(4'h1, 100, 100, -1, -1, 1'b1, 1'b0));
        foreach (tbl[i]) begin
            exp_s = predict(tbl[i]);
            run_cmd(tbl[i]);
            got_s = observed();
            checks++;
            if (got_s != exp_s) begin
                errors++; $display("FAIL abort[%0d] op=%h got %s exp %s", i, tbl[i].op, got_s, exp_s);
            end
        end
    endtask

    task automatic test_ignore();
        cmd_t  tbl[$];
        string exp_s, got_s;
        sel4 = 1'b0;
        tbl.push_back(mk(4'h1, 60, 60, -1, -1, 1'b0, 1'b1));
        tbl.push_back(mk(4'h3, 100, 50, -1, -1, 1'b0, 1'b1));
        foreach (tbl[i]) begin
            exp_s = predict(tbl[i]);
            run_cmd(tbl[i]);
            got_s = observed();
            checks++;
            if (got_s != exp_s) begin
                errors++; $display("FAIL ignore[%0d] got %s exp %s", i, got_s, exp_s);
            end
        end
    endtask

    task automatic test_param();
        cmd_t  c;
        string exp_s, got_s;
        sel4 = 1'b1;
        c = mk(4'h1, 60, 60, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL dim4_random got %s exp %s", got_s, exp_s); end
        c = mk(4'h1, 100, 100, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL dim4_full got %s exp %s", got_s, exp_s); end
        checks++;
        if (obs_busy != 32 + 11 + 16 + 1) begin
            errors++; $display("FAIL dim4_busy_cycles got %0d exp %0d", obs_busy, 60);
        end
    endtask

    task automatic test_async_reset();
        int    seen = 0;
        cmd_t  c;
        string exp_s, got_s;
        sel4 = 1'b1;
        @(negedge clk);
        start = 1'b1; instr = 4'h1; host_valid = 1'b1; host_wb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < BUDGET && seen < 2; k++) begin
            @(negedge clk);
            #1;
            if (o_wb) seen++;
        end
        checks++;
        if (!(seen == 2 && o_wb && o_busy)) begin
            errors++; $display("FAIL areset_reach_wb got seen=%0d wb=%b busy=%b exp seen=2 wb=1 busy=1",
                               seen, o_wb, o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_req, o_wm_load, o_mmu, o_wb, o_busy, o_done, o_err} !== 7'd0 || o_wm_addr != 0 || o_wb_addr != 0) begin
            errors++;
            $display("FAIL areset_immediate got %b%b%b%b%b%b%b/%0d/%0d exp 0000000/0/0",
                     o_req, o_wm_load, o_mmu, o_wb, o_busy, o_done, o_err, o_wm_addr, o_wb_addr);
        end
        host_valid = 1'b0; host_wb_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_wts[0] = 1'b0; model_wts[1] = 1'b0;
        c = mk(4'h3, 100, 100, -1, -1, 1'b0, 1'b0);
        exp_s = predict(c);
        run_cmd(c);
        got_s = observed();
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL areset_cwb_after got %s exp %s", got_s, exp_s); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_backpressure();
        test_modes();
        test_abort();
        test_ignore();
        test_param();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
